// File: rtl/pooling_sequencer.sv
// 2x2 average-pooling sequencer: reads a SIDE x SIDE frame one pixel per cycle and writes the
// (SIDE/2)^2 window averages. Define POOL_ROUND_EN for round-half-up averaging (default truncates).
module pooling_sequencer #(
  parameter  int DATA_W = 8,
  parameter  int SIDE   = 28,
  localparam int HALF   = SIDE / 2,
  localparam int PIX_N  = SIDE * SIDE,
  localparam int AVG_N  = HALF * HALF,
  localparam int RD_AW  = $clog2(PIX_N),
  localparam int WR_AW  = $clog2(AVG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [RD_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [WR_AW-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int SUM_W = DATA_W + 2;
  localparam int CW    = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LAST = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [1:0]        k;
  logic [CW-1:0]     r;
  logic [CW-1:0]     c;
  logic [RD_AW-1:0]  base;
  logic [SUM_W-1:0]  sum;

  logic              last_col;
  logic              last_win;
  logic [RD_AW-1:0]  base_next;

  // Offset of beat kk inside a window: TL, TR, BL, BR.
  function automatic logic [RD_AW-1:0] beat_offset(input logic [1:0] kk);
    logic [RD_AW-1:0] off;
    case (kk)
      2'd0:    off = '0;
      2'd1:    off = RD_AW'(1);
      2'd2:    off = RD_AW'(SIDE);
      default: off = RD_AW'(SIDE + 1);
    endcase
    return off;
  endfunction

  // The +2 cannot overflow SUM_W bits: 4*(2^DATA_W-1)+2 < 2^SUM_W.
  function automatic logic [DATA_W-1:0] pool_avg(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
`ifdef POOL_ROUND_EN
    t = s + SUM_W'(2);
`else
    t = s;
`endif
    return DATA_W'(t >> 2);
  endfunction

  assign last_col  = (c == CW'(HALF - 1));
  assign last_win  = last_col && (r == CW'(HALF - 1));
  // Leaving the last column skips the odd row already covered by the BL/BR beats.
  assign base_next = last_col ? (base + RD_AW'(2 + SIDE)) : (base + RD_AW'(2));

  // wr_data is decoded from the sum register so rd_data never reaches an output directly.
  assign wr_data = (state == WR) ? pool_avg(sum) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      k       <= '0;
      r       <= '0;
      c       <= '0;
      base    <= '0;
      sum     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            k       <= '0;
            rd_en   <= 1'b1;
            rd_addr <= base;
          end
        end

        READ: begin
          // Read data lags the strobe by one cycle, so beat k accumulates pixel k-1.
          if (k == 2'd0) sum <= '0;
          else           sum <= sum + SUM_W'(rd_data);
          if (k == 2'd3) begin
            state <= LAST;
            rd_en <= 1'b0;
          end else begin
            k       <= k + 2'd1;
            rd_addr <= base + beat_offset(k + 2'd1);
          end
        end

        LAST: begin
          sum   <= sum + SUM_W'(rd_data);
          state <= WR;
          wr_en <= 1'b1;
        end

        WR: begin
          wr_en <= 1'b0;
          k     <= '0;
          if (last_win) begin
            state   <= DONE;
            done    <= 1'b1;
            r       <= '0;
            c       <= '0;
            base    <= '0;
            wr_addr <= '0;
          end else begin
            state   <= READ;
            rd_en   <= 1'b1;
            rd_addr <= base_next;
            base    <= base_next;
            wr_addr <= wr_addr + WR_AW'(1);
            if (last_col) begin
              c <= '0;
              r <= r + CW'(1);
            end else begin
              c <= c + CW'(1);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          rd_en <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
